// File: rtl/multicast_ctrl.sv
// Row-bus multicast receiver: claims words whose ID matches the loaded tag (or broadcast) into a FWFT staging FIFO.
// One cycle bus-to-PE latency; bus_ready drops only for matching IDs while full and never depends on pe_ready.
module multicast_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush_tag,
    input  logic [ID_WIDTH-1:0]           tag_in,
    input  logic [ID_WIDTH-1:0]           bus_id,
    input  logic                          bus_valid,
    output logic                          bus_ready,
    input  logic [DATA_WIDTH-1:0]         bus_ifmap,
    input  logic [DATA_WIDTH-1:0]         bus_fltr,
    input  logic [2*DATA_WIDTH-1:0]       bus_psum,
    output logic [DATA_WIDTH-1:0]         pe_ifmap,
    output logic [DATA_WIDTH-1:0]         pe_fltr,
    output logic [2*DATA_WIDTH-1:0]       pe_psum,
    output logic                          pe_valid,
    input  logic                          pe_ready,
    output logic                          tag_valid,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   ifmap;
        logic [DATA_WIDTH-1:0]   fltr;
        logic [2*DATA_WIDTH-1:0] psum;
    } payload_t;

    typedef enum logic {UNARMED = 1'b0, ARMED = 1'b1} state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_WIDTH-1:0] tag;
    payload_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [OCC_W-1:0]    count;
    logic                match;
    logic                full;
    logic                push;
    logic                pop;
    payload_t            head;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= UNARMED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush_tag) state_next = ARMED;
    end

    always_comb begin
        tag_valid = (state == ARMED);
    end

    assign match     = tag_valid & ((bus_id == tag) | (bus_id == {ID_WIDTH{1'b1}}));
    assign full      = (count == OCC_W'(FIFO_DEPTH));
    assign bus_ready = tag_valid & ~flush_tag & (~match | ~full);
    assign push      = bus_valid & bus_ready & match;
    assign pop       = pe_valid & pe_ready & ~flush_tag;
    assign pe_valid  = (count != '0);
    assign occupancy = count;

    // Empty FIFO presents zeros so stale or reset-era storage never leaks out.
    assign head     = pe_valid ? mem[rd_ptr] : '0;
    assign pe_ifmap = head.ifmap;
    assign pe_fltr  = head.fltr;
    assign pe_psum  = head.psum;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{ifmap: bus_ifmap, fltr: bus_fltr, psum: bus_psum};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_tag) begin
            tag    <= tag_in;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_multicast_ctrl.sv
// Randomized and directed bench for multicast_ctrl against a queue-based model of the tag/FIFO behaviour.
module tb_multicast_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush_tag = 1'b0;
    logic [3:0]  tag_in = '0;
    logic [3:0]  bus_id = '0;
    logic        bus_valid = 1'b0;
    logic        bus_ready;
    logic [15:0] bus_ifmap = '0;
    logic [15:0] bus_fltr = '0;
    logic [31:0] bus_psum = '0;
    logic [15:0] pe_ifmap;
    logic [15:0] pe_fltr;
    logic [31:0] pe_psum;
    logic        pe_valid;
    logic        pe_ready = 1'b0;
    logic        tag_valid;
    logic [2:0]  occupancy;

    multicast_ctrl #(.DATA_WIDTH(16), .ID_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush_tag(flush_tag), .tag_in(tag_in),
        .bus_id(bus_id), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_ifmap(bus_ifmap), .bus_fltr(bus_fltr), .bus_psum(bus_psum),
        .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr), .pe_psum(pe_psum),
        .pe_valid(pe_valid), .pe_ready(pe_ready), .tag_valid(tag_valid),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: armed flag, tag, and a queue of {ifmap, fltr, psum} entries.
    logic        m_armed = 1'b0;
    logic [3:0]  m_tag = '0;
    logic [63:0] m_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_tag   = '0;
        m_q.delete();
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then advance the model over the coming edge.
    task automatic step(input logic fl, input logic [3:0] ti, input logic [3:0] bid, input logic bv,
                        input logic [15:0] fi, input logic [15:0] ff, input logic [31:0] ps, input logic pr);
        logic        m_match;
        logic        m_ready;
        logic [63:0] m_head;
        @(negedge clk);
        flush_tag = fl; tag_in = ti; bus_id = bid; bus_valid = bv;
        bus_ifmap = fi; bus_fltr = ff; bus_psum = ps; pe_ready = pr;
        #1;
        m_match = m_armed && (bid == m_tag || bid == 4'hF);
        m_ready = m_armed && !fl && (!m_match || m_q.size() < DEPTH);
        m_head  = (m_q.size() != 0) ? m_q[0] : 64'h0;
        chk("tag_valid", 64'(tag_valid), 64'(m_armed));
        chk("bus_ready", 64'(bus_ready), 64'(m_ready));
        chk("pe_valid",  64'(pe_valid),  64'(m_q.size() != 0));
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        chk("pe_payload", {pe_ifmap, pe_fltr, pe_psum}, m_head);
        if (fl) begin
            m_armed = 1'b1;
            m_tag   = ti;
            m_q.delete();
        end else begin
            if (pr && m_q.size() != 0) void'(m_q.pop_front());
            if (bv && m_ready && m_match) m_q.push_back({fi, ff, ps});
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #13;
        chk("rst_tag_valid", 64'(tag_valid), 64'h0);
        chk("rst_bus_ready", 64'(bus_ready), 64'h0);
        chk("rst_pe_valid",  64'(pe_valid),  64'h0);
        chk("rst_occupancy", 64'(occupancy), 64'h0);
        chk("rst_pe_psum",   64'(pe_psum),   64'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Unarmed: bus_id equals the reset tag value but nothing may be accepted.
        step(0, 0, 0, 1, 16'h5, 16'h6, 32'h7, 1);
        chk("unarmed_bus_ready", 64'(bus_ready), 64'h0);
        after_edge();
        chk("unarmed_occupancy", 64'(occupancy), 64'h0);

        // Tag load and matched stream with an always-ready PE.
        step(1, 3, 0, 0, 0, 0, 0, 1);
        after_edge();
        chk("armed_tag_valid", 64'(tag_valid), 64'h1);
        step(0, 0, 3, 1, 16'h11, 16'h1, 32'h1, 1);
        after_edge();
        chk("stream_ifmap0", 64'(pe_ifmap), 64'h11);
        chk("stream_occ0",   64'(occupancy), 64'h1);
        step(0, 0, 3, 1, 16'h22, 16'h2, 32'h2, 1);
        after_edge();
        chk("stream_ifmap1", 64'(pe_ifmap), 64'h22);
        chk("stream_occ1",   64'(occupancy), 64'h1);
        step(0, 0, 3, 1, 16'h33, 16'h3, 32'h3, 1);
        after_edge();
        chk("stream_ifmap2", 64'(pe_ifmap), 64'h33);
        chk("stream_occ2",   64'(occupancy), 64'h1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Mismatch is accepted and discarded.
        step(0, 0, 5, 1, 16'hBAD, 16'hBAD, 32'hBAD, 1);
        chk("mismatch_bus_ready", 64'(bus_ready), 64'h1);
        after_edge();
        chk("mismatch_occupancy", 64'(occupancy), 64'h0);
        chk("mismatch_pe_valid",  64'(pe_valid),  64'h0);

        // Broadcast ID reaches a PE tagged 2.
        step(1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 4'hF, 1, 16'h0, 16'h0, 32'h0001_0002, 0);
        after_edge();
        chk("bcast_pe_psum",   64'(pe_psum),   64'h0001_0002);
        chk("bcast_occupancy", 64'(occupancy), 64'h1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Fill to full, then backpressure only on matching IDs.
        for (int i = 0; i < 4; i++) step(0, 0, 2, 1, 16'hA0 + 16'(i), 16'(i), 32'(i), 0);
        step(0, 0, 2, 1, 16'hEE, 0, 0, 0);
        chk("full_occupancy",      64'(occupancy), 64'h4);
        chk("full_match_ready",    64'(bus_ready), 64'h0);
        step(0, 0, 5, 1, 16'hEE, 0, 0, 0);
        chk("full_nomatch_ready",  64'(bus_ready), 64'h1);
        step(0, 0, 2, 1, 16'hEE, 0, 0, 1);
        chk("full_pop_ready_low",  64'(bus_ready), 64'h0);
        after_edge();
        chk("after_pop_occupancy", 64'(occupancy), 64'h3);
        chk("after_pop_head",      64'(pe_ifmap),  64'hA1);
        step(0, 0, 2, 1, 16'hA4, 0, 0, 0);
        chk("after_pop_ready",     64'(bus_ready), 64'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);

        // Flush with push and pop in flight.
        for (int i = 0; i < 3; i++) step(0, 0, 2, 1, 16'hC0 + 16'(i), 0, 0, 0);
        after_edge();
        chk("preflush_occupancy", 64'(occupancy), 64'h3);
        step(1, 7, 2, 1, 16'hDD, 0, 0, 1);
        after_edge();
        chk("flush_occupancy", 64'(occupancy), 64'h0);
        chk("flush_pe_valid",  64'(pe_valid),  64'h0);
        chk("flush_tag_valid", 64'(tag_valid), 64'h1);
        step(0, 0, 7, 1, 16'h77, 0, 0, 0);
        after_edge();
        chk("newtag_occupancy", 64'(occupancy), 64'h1);

        // Asynchronous reset between edges with two entries held.
        step(0, 0, 7, 1, 16'h78, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("prereset_occupancy", 64'(occupancy), 64'h2);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_tag_valid", 64'(tag_valid), 64'h0);
        chk("arst_pe_valid",  64'(pe_valid),  64'h0);
        chk("arst_bus_ready", 64'(bus_ready), 64'h0);
        chk("arst_occupancy", 64'(occupancy), 64'h0);
        chk("arst_pe_ifmap",  64'(pe_ifmap),  64'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic with a small ID space so matches, broadcasts and flushes all occur.
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] rid;
            logic [3:0] rtag;
            rid  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
            rtag = 4'($urandom_range(0, 3));
            step(($urandom_range(0, 24) == 0) || (i == 0), rtag, rid, 1'($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom), $urandom, 1'($urandom_range(0, 9) < 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
